cfa_seq: RTL and testbench
==========================

CFA_SEQ -- requirements
Module: cfa_seq

Interface
REQ-001 SHALL have parameter NIB, default 4, giving the number of 4-bit nibbles (operand width W = 4*NIB, legal range 2..8).
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1  request one operation, sampled only in IDLE.
REQ-005 SHALL have port SUB  input  1  0 = A+B, 1 = A-B, sampled with start.
REQ-006 SHALL have port A  input  W  operand A, sampled with start.
REQ-007 SHALL have port B  input  W  operand B, sampled with start.
REQ-008 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-009 SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-010 SHALL have port F  output  W  result.
REQ-011 SHALL have port CO  output  1  carry out of MSB (for SUB, 1 = no borrow).
REQ-012 SHALL have port OV  output  1  signed overflow (see Configuration).

Function
REQ-013 SHALL implement states IDLE, RUN and DONE.
REQ-014 Transitions SHALL be: IDLE->RUN on start=1; RUN->DONE after nibble NIB-1 is written; DONE->IDLE unconditionally.
REQ-015 On the edge accepting start, the block SHALL latch A, B and SUB, clear nibble index idx to 0, and load the carry register with SUB.
REQ-016 In RUN, each cycle SHALL feed nibble idx of A, nibble idx of B (inverted when SUB=1) and the carry register to one 4-bit adder.
REQ-017 At the end of each RUN cycle, the adder sum SHALL be written to F[4*idx+3:4*idx], its carry out stored to the carry register, and idx incremented.
REQ-018 Latency SHALL be fixed: start sampled at edge k, last nibble written at edge k+NIB, done=1 in the cycle after edge k+NIB, i.e. exactly NIB+1 cycles start-to-done.
REQ-019 CO SHALL equal the final carry register value and SHALL update on the same edge as the MSB nibble.
REQ-020 F, CO and OV SHALL hold their values from DONE until the next accepted start; bits of F not yet rewritten in a new operation are don't-care while busy=1.
REQ-021 start while busy=1 (RUN or DONE) SHALL be ignored, with no queuing; start held high continuously SHALL yield back-to-back operations separated by one IDLE cycle.
REQ-022 Changes on A, B or SUB after acceptance SHALL NOT affect the operation in progress.
REQ-023 Arithmetic SHALL be modulo 2^W; subtraction SHALL be A + ~B + 1.

Reset
REQ-024 rst_n=0 SHALL immediately force state IDLE, idx=0, carry=0, F=0, CO=0, OV=0, busy=0 and done=0, including mid-operation; the aborted operation SHALL produce no done.
REQ-025 The first start after rst_n deasserts SHALL be accepted normally.

Configuration
REQ-026 With macro CFA_SEQ_OVF_EN defined, OV SHALL be set at the MSB write to (A[W-1] == B'[W-1]) and (F[W-1] != A[W-1]), where B' is B after optional inversion.
REQ-027 Without CFA_SEQ_OVF_EN, OV SHALL be tied 0 and no overflow logic SHALL be synthesized; the port remains present.

Structure
REQ-028 The state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the constant NIBBLE_W=4 SHALL live in shared header cfa_defs.vh.
REQ-029 The block SHALL instantiate exactly one existing 4-bit lookahead adder carryfa (ports A, B, C0, C4, F) as its only datapath sub-module.
REQ-030 The block SHALL NOT infer a W-bit adder.

Verification (NIB=4)
REQ-031 A=16'hC0B3, B=16'h1234, SUB=0 -> done 5 cycles after start, F=16'hD2E7, CO=0, OV=0.
REQ-032 A=16'hFFFF, B=16'h0001, SUB=0 -> F=16'h0000, CO=1, OV=0, verifying carry ripple across all nibbles.
REQ-033 A=16'h0005, B=16'h0007, SUB=1 -> F=16'hFFFE, CO=0. A=16'h7FFF, B=16'h0001, SUB=0 -> F=16'h8000, OV=1 with CFA_SEQ_OVF_EN and OV=0 without.
REQ-034 Pulse start again 2 cycles into an operation with different A -> ignored, first result correct, single done. Start held high -> done every 6 cycles.
REQ-035 Assert rst_n=0 during the 3rd RUN cycle -> all outputs 0 immediately, no done; a new start after release gives a correct result.

Source files
------------

// File: rtl/cfa_seq_pkg.sv
// Shared definitions for the nibble-serial adder/subtractor: FSM encoding and nibble width.
package cfa_seq_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cfa_seq_carryfa.sv
// 4-bit carry-lookahead adder: all internal carries computed in parallel from generate/propagate.
module carryfa (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       C0,
  output logic       C4,
  output logic [3:0] F
);

  logic [3:0] g;
  logic [3:0] p;
  logic       c1;
  logic       c2;
  logic       c3;

  assign g  = A & B;
  assign p  = A ^ B;
  assign c1 = g[0] | (p[0] & C0);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & C0);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & C0);
  assign C4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & C0);
  assign F  = p ^ {c3, c2, c1, C0};

endmodule

// File: rtl/cfa_seq.sv
// Nibble-serial W-bit add/subtract through one 4-bit lookahead adder, NIB+1 cycles per operation.
// Define CFA_SEQ_OVF_EN to build the signed-overflow flag; otherwise OV is tied low.
import cfa_seq_pkg::*;

module cfa_seq #(
  parameter int NIB = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  SUB,
  input  logic [NIBBLE_W*NIB-1:0] A,
  input  logic [NIBBLE_W*NIB-1:0] B,
  output logic                  busy,
  output logic                  done,
  output logic [NIBBLE_W*NIB-1:0] F,
  output logic                  CO,
  output logic                  OV
);

  localparam int         W    = NIBBLE_W * NIB;
  localparam logic [2:0] LAST = 3'(NIB - 1);

  state_t                state;
  logic [2:0]            idx;
  logic                  carry;
  logic [W-1:0]          a_r;
  logic [W-1:0]          b_r;
  logic [NIBBLE_W-1:0]   a_nib;
  logic [NIBBLE_W-1:0]   b_nib;
  logic [NIBBLE_W-1:0]   sum;
  logic                  c_out;

  assign a_nib = a_r[NIBBLE_W*idx +: NIBBLE_W];
  assign b_nib = b_r[NIBBLE_W*idx +: NIBBLE_W];

  carryfa u_add (
    .A  (a_nib),
    .B  (b_nib),
    .C0 (carry),
    .C4 (c_out),
    .F  (sum)
  );

  // B is stored already inverted for subtraction; the +1 comes from the carry preload.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      a_r <= A;
      b_r <= SUB ? ~B : B;
    end
  end

`ifdef CFA_SEQ_OVF_EN
  logic ov_r;
  assign OV = ov_r;
`else
  assign OV = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= 3'd0;
      carry <= 1'b0;
      F     <= '0;
      CO    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef CFA_SEQ_OVF_EN
      ov_r  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            idx   <= 3'd0;
            carry <= SUB;
          end
        end
        RUN: begin
          F[NIBBLE_W*idx +: NIBBLE_W] <= sum;
          carry <= c_out;
          idx   <= idx + 3'd1;
          if (idx == LAST) begin
            state <= DONE;
            done  <= 1'b1;
            CO    <= c_out;
`ifdef CFA_SEQ_OVF_EN
            ov_r  <= (a_r[W-1] == b_r[W-1]) && (sum[NIBBLE_W-1] != a_r[W-1]);
`endif
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cfa_seq.sv
// Directed bench for cfa_seq (NIB=4): vector table plus busy-start, held-start and mid-run reset sequences.
module tb_cfa_seq;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] f;
  logic         co;
  logic         ov;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cfa_seq #(.NIB(NIB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .SUB   (sub),
    .A     (a),
    .B     (b),
    .busy  (busy),
    .done  (done),
    .F     (f),
    .CO    (co),
    .OV    (ov)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] f;
    logic         co;
    logic         ov;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  // Returns the number of rising edges after acceptance until done is seen (-1 on timeout).
  task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vs,
                        output int lat);
    wait_idle();
    a     = va;
    b     = vb;
    sub   = vs;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = c;
        break;
      end
    end
  endtask

  int   lat;
  int   ndone;
  int   d1;
  int   d2;
  logic [W-1:0] fcap;
  logic ov_exp;

  initial begin
`ifdef CFA_SEQ_OVF_EN
    ov_exp = 1'b1;
`else
    ov_exp = 1'b0;
`endif
    vecs[0] = '{16'hC0B3, 16'h1234, 1'b0, 16'hD2E7, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, ov_exp};
    vecs[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, ov_exp};
    vecs[5] = '{16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[6] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[7] = '{16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0, 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_f", 32'(f), 32'd0);
    chk("rst_co", 32'(co), 32'd0);
    chk("rst_ov", 32'(ov), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].sub, lat);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(NIB));
      chk($sformatf("v%0d_f", i), 32'(f), 32'(vecs[i].f));
      chk($sformatf("v%0d_co", i), 32'(co), 32'(vecs[i].co));
      chk($sformatf("v%0d_ov", i), 32'(ov), 32'(vecs[i].ov));
      chk($sformatf("v%0d_busy_in_done", i), 32'(busy), 32'd1);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
      chk($sformatf("v%0d_f_hold", i), 32'(f), 32'(vecs[i].f));
    end

    // start re-pulsed two cycles into an operation, with new operands, must be ignored
    wait_idle();
    a = 16'h1111; b = 16'h2222; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
    @(posedge clk);
    @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF; sub = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    ndone = 0;
    fcap  = '0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        fcap = f;
      end
    end
    chk("busy_start_ndone", 32'(ndone), 32'd1);
    chk("busy_start_f", 32'(fcap), 32'h3333);

    // start held high: back-to-back operations with one IDLE cycle between
    wait_idle();
    a = 16'h0001; b = 16'h0002; sub = 1'b0; start = 1'b1;
    d1 = -1;
    d2 = -1;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        if (d1 < 0) d1 = c;
        else if (d2 < 0) d2 = c;
      end
    end
    start = 1'b0;
    chk("held_period", 32'(d2 - d1), 32'd6);
    chk("held_f", 32'(f), 32'h0003);

    // reset during the third RUN cycle, after a result that left CO=1
    run_op(16'hFFFF, 16'h0001, 1'b0, lat);
    chk("pre_reset_co", 32'(co), 32'd1);
    wait_idle();
    a = 16'h0F0F; b = 16'h0101; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_f", 32'(f), 32'd0);
    chk("mid_rst_co", 32'(co), 32'd0);
    chk("mid_rst_ov", 32'(ov), 32'd0);
    ndone = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    chk("aborted_no_done", 32'(ndone), 32'd0);
    run_op(16'h0F0F, 16'h0101, 1'b0, lat);
    chk("post_rst_latency", 32'(lat), 32'(NIB));
    chk("post_rst_f", 32'(f), 32'h1010);
    chk("post_rst_co", 32'(co), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
